// File: rtl/calc_entry_ctrl.sv
// Keypad front end for the sign-magnitude arithmetic unit: builds hex operands,
// keeps the running accumulator and sequences issue / wait / capture of each result.
module calc_entry_ctrl #(
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned ANS_WAIT   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [4:0]  key_code,
  output logic        key_ready,
  output logic [16:0] V1,
  output logic [16:0] V2,
  output logic [1:0]  opcode,
  output logic        newop,
  input  logic [16:0] answer,
  input  logic        ovw,
  output logic [16:0] disp_value,
  output logic        busy,
  output logic        error
);

  localparam int unsigned DW   = 17;
  localparam int unsigned MW   = 16;
  localparam int unsigned OPW  = 2;
  localparam int unsigned DCW  = $clog2(MAX_DIGITS + 1);
  localparam int unsigned CNTW = $clog2(ANS_WAIT + 1);

  localparam logic [4:0] K_ADD = 5'h10;
  localparam logic [4:0] K_MUL = 5'h11;
  localparam logic [4:0] K_SUB = 5'h12;
  localparam logic [4:0] K_EQ  = 5'h13;
  localparam logic [4:0] K_SGN = 5'h14;
  localparam logic [4:0] K_CLR = 5'h15;

  typedef enum logic [2:0] {
    S_ENTRY   = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_ERROR   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [DW-1:0]   entry_q, entry_d;
  logic [DCW-1:0]  digit_cnt_q, digit_cnt_d;
  logic            pend_vld_q, pend_vld_d;
  logic [OPW-1:0]  pend_op_q, pend_op_d;
  logic            next_vld_q, next_vld_d;
  logic [OPW-1:0]  next_op_q, next_op_d;
  logic [CNTW-1:0] wait_cnt_q, wait_cnt_d;
  logic [DW-1:0]   ans_q, ans_d;
  logic            ovw_q, ovw_d;
  logic [OPW-1:0]  opcode_q, opcode_d;
  logic            newop_q, newop_d;
  logic            busy_q, busy_d;
  logic            error_q, error_d;
  logic            key_ready_q, key_ready_d;
  logic [DW-1:0]   disp_q, disp_d;
  logic            key_fire;
  logic            do_clear;

  assign key_fire = key_valid & key_ready_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    entry_d     = entry_q;
    digit_cnt_d = digit_cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_op_d   = pend_op_q;
    next_vld_d  = next_vld_q;
    next_op_d   = next_op_q;
    wait_cnt_d  = wait_cnt_q;
    ans_d       = ans_q;
    ovw_d       = ovw_q;
    opcode_d    = opcode_q;
    do_clear    = 1'b0;

    case (state_q)
      S_ENTRY: begin
        if (key_fire) begin
          if (!key_code[4]) begin
            if (digit_cnt_q < DCW'(MAX_DIGITS)) begin
              entry_d     = {entry_q[DW-1], entry_q[11:0], key_code[3:0]};
              digit_cnt_d = digit_cnt_q + DCW'(1);
            end
          end else begin
            case (key_code)
              K_SGN: entry_d[DW-1] = ~entry_q[DW-1];
              K_ADD, K_MUL, K_SUB: begin
                if (!pend_vld_q) begin
                  if (digit_cnt_q != '0) acc_d = entry_q;
                  pend_vld_d  = 1'b1;
                  pend_op_d   = key_code[1:0];
                  entry_d     = '0;
                  digit_cnt_d = '0;
                end else if (digit_cnt_q == '0) begin
                  pend_op_d = key_code[1:0];
                end else begin
                  next_vld_d = 1'b1;
                  next_op_d  = key_code[1:0];
                  opcode_d   = pend_op_q;
                  state_d    = S_ISSUE;
                end
              end
              K_EQ: begin
                if (pend_vld_q && (digit_cnt_q != '0)) begin
                  next_vld_d = 1'b0;
                  next_op_d  = '0;
                  opcode_d   = pend_op_q;
                  state_d    = S_ISSUE;
                end
              end
              K_CLR:   do_clear = 1'b1;
              default: ;
            endcase
          end
        end
      end
      S_ISSUE: begin
        wait_cnt_d = CNTW'(ANS_WAIT - 2);
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // Sample on the edge that is ANS_WAIT edges after the newop edge
        if (wait_cnt_q == '0) begin
          ans_d   = answer;
          ovw_d   = ovw;
          state_d = S_CAPTURE;
        end else begin
          wait_cnt_d = wait_cnt_q - CNTW'(1);
        end
      end
      S_CAPTURE: begin
        if (ovw_q) begin
          state_d = S_ERROR;
        end else begin
          acc_d       = {ans_q[DW-1] & (ans_q[MW-1:0] != '0), ans_q[MW-1:0]};
          entry_d     = '0;
          digit_cnt_d = '0;
          pend_vld_d  = next_vld_q;
          pend_op_d   = next_op_q;
          state_d     = S_ENTRY;
        end
      end
      S_ERROR: begin
        if (key_fire && (key_code == K_CLR)) do_clear = 1'b1;
      end
      default: state_d = S_ENTRY;
    endcase

    if (do_clear) begin
      acc_d       = '0;
      entry_d     = '0;
      digit_cnt_d = '0;
      pend_vld_d  = 1'b0;
      pend_op_d   = '0;
      next_vld_d  = 1'b0;
      next_op_d   = '0;
      state_d     = S_ENTRY;
    end

    newop_d     = (state_d == S_ISSUE);
    busy_d      = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_CAPTURE);
    error_d     = (state_d == S_ERROR);
    key_ready_d = (state_d == S_ENTRY) || (state_d == S_ERROR);
    disp_d      = (digit_cnt_d != '0) ? entry_d : acc_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_ENTRY;
      acc_q       <= '0;
      entry_q     <= '0;
      digit_cnt_q <= '0;
      pend_vld_q  <= 1'b0;
      pend_op_q   <= '0;
      next_vld_q  <= 1'b0;
      next_op_q   <= '0;
      wait_cnt_q  <= '0;
      ans_q       <= '0;
      ovw_q       <= 1'b0;
      opcode_q    <= '0;
      newop_q     <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
      key_ready_q <= 1'b1;
      disp_q      <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      entry_q     <= entry_d;
      digit_cnt_q <= digit_cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_op_q   <= pend_op_d;
      next_vld_q  <= next_vld_d;
      next_op_q   <= next_op_d;
      wait_cnt_q  <= wait_cnt_d;
      ans_q       <= ans_d;
      ovw_q       <= ovw_d;
      opcode_q    <= opcode_d;
      newop_q     <= newop_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
      key_ready_q <= key_ready_d;
      disp_q      <= disp_d;
    end
  end

  assign V1         = entry_q;
  assign V2         = acc_q;
  assign opcode     = opcode_q;
  assign newop      = newop_q;
  assign busy       = busy_q;
  assign error      = error_q;
  assign key_ready  = key_ready_q;
  assign disp_value = disp_q;

endmodule

// File: doc/calc_entry_ctrl.md
Name: calc_entry_ctrl

Overview:
- Front-end controller that drives the sign-magnitude arithmetic unit.
- Accepts keypad key codes through a valid/ready handshake and builds a 16-bit hex operand with sign.
- Holds a running accumulator and issues operand/opcode/newop to the arithmetic unit.
- Waits a fixed latency, captures answer/ovw into the accumulator and supports chained operations and error handling.

Parameters:
MAX_DIGITS, 4, maximum hex digits accepted per operand (1..4)
ANS_WAIT, 2, cycles from the newop edge until answer/ovw are sampled (must be >= 2)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
key_valid  in  1  key_code present
key_code  in  5  0x00-0x0F digit; 0x10 '+'; 0x11 '*'; 0x12 '-'; 0x13 '='; 0x14 sign toggle; 0x15 clear; others ignored
key_ready  out  1  key accepted on cycles where key_valid & key_ready
V1  out  17  second operand, sign-magnitude (bit16 = sign), driven from entry register
V2  out  17  first operand, sign-magnitude, driven from accumulator
opcode  out  2  00 add, 01 multiply, 10 subtract (unit computes V2-V1)
newop  out  1  one-cycle pulse, opcode valid
answer  in  17  sign-magnitude result from arithmetic unit
ovw  in  1  overflow flag from arithmetic unit
disp_value  out  17  entry if digits entered since last operator/'=', else accumulator
busy  out  1  high in ISSUE/WAIT/CAPTURE
error  out  1  high in ERROR

Behaviour:
- Reset values:
  - acc = 0, entry = 0, digit_cnt = 0, pend_op = none.
  - opcode = 00, newop = 0, error = 0, busy = 0, key_ready = 1, disp_value = 0.
  - State ENTRY, wait counter = 0.
  - Reset mid-operation abandons any computation; no newop follows.
- States: ENTRY, ISSUE, WAIT, CAPTURE, ERROR.
- ENTRY (key_ready = 1):
  - Digit:
    - If digit_cnt < MAX_DIGITS: entry magnitude <= {mag[11:0], digit}, digit_cnt++.
    - Otherwise the digit is ignored.
  - Sign toggle: entry sign flips. Sign and zero-digit state are independent.
  - Operator (+ * -) with pend_op = none:
    - If digit_cnt > 0, acc <= entry; otherwise acc is unchanged.
    - pend_op <= key; entry and digit_cnt cleared.
  - Operator with pend_op set and digit_cnt = 0: pend_op replaced by the new key. No computation.
  - Operator or '=' with pend_op set and digit_cnt > 0:
    - Latch next_op (the new key, or none for '=').
    - opcode <= pend_op; go to ISSUE.
  - '=' with pend_op = none: ignored.
  - Clear: acc, entry, digit_cnt, pend_op all reset.
- ISSUE (1 cycle): newop = 1; V1/V2/opcode stable. Next state WAIT, counter loaded.
- WAIT:
  - Count ANS_WAIT-1 cycles.
  - answer/ovw are sampled at the edge ending the last WAIT cycle, i.e. ANS_WAIT edges after the newop edge.
- CAPTURE (1 cycle):
  - If ovw = 1: go to ERROR; acc unchanged.
  - Otherwise:
    - acc <= answer, with the sign forced to 0 when magnitude = 0.
    - entry and digit_cnt cleared; pend_op <= next_op.
    - Return to ENTRY.
- V1, V2 and opcode are held constant from ISSUE through CAPTURE.
- busy: key_ready = 0, so keys stall and none are lost.
- ERROR:
  - error = 1, key_ready = 1.
  - All keys except clear are consumed and ignored.
  - Clear performs the full clear and returns to ENTRY with error = 0.
- Accepting a key and a state transition on the same edge is legal; only one key is processed per cycle.

Test Plan:
- Basic add:
  - Stimulus: keys 1,2,+,3,4,=.
  - Required: single newop pulse with V2=0x00012, V1=0x00034, opcode=00.
  - ANS_WAIT edges later, acc=0x00046, disp_value=0x00046, busy low, key_ready back high.
- Negative subtract:
  - Stimulus: 5,-,9,=.
  - Required: V2=0x00005, V1=0x00009, opcode=10; answer 0x10004 captured, disp_value=0x10004.
- Chaining:
  - Stimulus: 2,+,3,*,4,=.
  - Required: first newop opcode=00 leaves acc=0x00005 and pend_op='*'; second newop opcode=01 with V1=0x00004; final acc=0x00014.
- Overflow:
  - Stimulus: 1,0,0,*,1,0,0,=.
  - Required: ovw=1 at capture, error=1; digit key ignored; clear gives acc=0 and error=0.
- Digit limit and handshake:
  - Stimulus: 1,2,3,4,5 gives entry 0x1234. key_valid held during busy gives key_ready=0, and the key is consumed only after CAPTURE.
- Reset mid-WAIT:
  - Stimulus: assert reset in the WAIT cycle.
  - Required: next cycle all outputs at reset values, no further newop, following '=' ignored.
